op_dispatch: RTL and testbench
==============================

Name: op_dispatch

Overview:
- Consumer end of the fetch op-queue interface.
- Each cycle it takes one decoded op bundle from the fetch side, renames its source operands against an internal register scoreboard (with same-cycle CDB bypass), allocates a ROB tag, and issues a registered dispatch packet to either the RS or the LSB.
- It tracks an outstanding JALR. When the JALR result appears on the CDB, it pulses rst_block_out to unblock fetch and presents the jump target.

Parameters:
- TAG_W, 4, ROB tag width; tags wrap modulo 2^TAG_W.
- JALR_OP, 5'd19, op encoding for JALR.
- NOP_OP, 5'd0, op encoding meaning "no instruction / bubble".

Ports:
- clk_in input 1 system clock
- rst_in input 1 synchronous active-high reset
- rdy_in input 1 global enable; low = freeze
- op_in input 5 op code from fetch queue
- rd_in input 5 destination register; 0 = no write
- rs1_in input 5 source 1 register
- rs2_in input 5 source 2 register
- imm_in input 32 immediate
- branch_in input 1 op is a branch
- ls_in input 1 op is load/store (route to LSB)
- use_imm_in input 1 rs2 replaced by immediate
- stall_out output 1 combinational; fetch must hold the current bundle while high
- rf_rs1_addr_out output 5 regfile read address 1 (= rs1_in)
- rf_rs2_addr_out output 5 regfile read address 2 (= rs2_in)
- rf_rs1_data_in input 32 combinational regfile data 1
- rf_rs2_data_in input 32 combinational regfile data 2
- rob_full_in input 1 ROB cannot accept
- rs_full_in input 1 RS cannot accept
- lsb_full_in input 1 LSB cannot accept
- cdb_valid_in input 1 CDB broadcast valid
- cdb_tag_in input TAG_W CDB tag
- cdb_data_in input 32 CDB value
- flush_in input 1 mispredict flush
- rs_valid_out output 1 dispatch packet valid for RS
- lsb_valid_out output 1 dispatch packet valid for LSB
- d_op_out output 5 dispatched op
- d_rd_out output 5 dispatched rd
- d_tag_out output TAG_W ROB tag of dispatched op
- d_vj_out output 32 operand 1 value
- d_qj_out output TAG_W operand 1 producer tag
- d_rj_out output 1 operand 1 ready
- d_vk_out output 32 operand 2 value
- d_qk_out output TAG_W operand 2 producer tag
- d_rk_out output 1 operand 2 ready
- d_imm_out output 32 immediate
- d_branch_out output 1 branch flag
- rst_block_out output 1 one-cycle pulse: JALR resolved, unblock fetch
- jalr_target_out output 32 JALR result value, valid while rst_block_out is high

Behaviour:
- Reset: every output register is cleared to 0. Scoreboard busy bits are cleared, next_tag is 0, FSM is in IDLE.
- rdy_in low: all state and outputs are held. stall_out is 1.
- present = (op_in != NOP_OP).
- target_full = ls_in ? lsb_full_in : rs_full_in.
- stall_out = present & (rob_full_in | target_full). Also forced to 1 while rdy_in is low.
- accept = present & !stall_out & !flush_in & rdy_in.
- Latency: a packet accepted in cycle N appears on the d_* outputs with rs_valid_out or lsb_valid_out high in cycle N+1, for exactly one cycle. Valid outputs are 0 in any cycle without an accept the cycle before.
- Operand 1 resolution, in priority order:
  - rs1 == 0: ready, value 0.
  - busy[rs1] and CDB match on tag[rs1]: ready, value cdb_data_in.
  - busy[rs1]: not ready, q = tag[rs1].
  - otherwise: ready, value rf_rs1_data_in.
- Operand 2 resolution: same rules on rs2. If use_imm_in is set, operand 2 is ready with value imm_in.
- Sources are resolved before the rd update, so an op with rs1 == rd reads the old mapping.
- Scoreboard write on accept with rd_in != 0: busy[rd] <= 1 and tag[rd] <= next_tag.
- Tag allocation: next_tag increments on every accept and wraps from 2^TAG_W-1 to 0.
- CDB clear: busy[r] <= 0 for every r where busy[r] is set and tag[r] == cdb_tag_in. A same-cycle dispatch writing r wins over the clear.
- JALR FSM:
  - IDLE: an accept with op_in == JALR_OP records jalr_tag <= next_tag and moves to WAIT.
  - WAIT: cdb_valid_in with cdb_tag_in == jalr_tag registers rst_block_out <= 1 and jalr_target_out <= cdb_data_in (both visible the next cycle), then returns to IDLE.
  - rst_block_out is a single-cycle pulse. Fetch is blocked during WAIT, so no second JALR arrives; one arriving anyway is dispatched without re-arming.
- flush_in has priority over everything else:
  - busy bits cleared, FSM to IDLE, valid outputs 0 next cycle, no rst_block_out pulse.
  - next_tag is reset to 0.
  - The bundle presented that cycle is discarded.

Test Plan:
- Reset, then op ADD x3 = x1 + x2 with regfile data 5/7 -> one cycle later rs_valid_out=1, tag=0, vj=5, vk=7, rj=rk=1; busy[3]=1.
- Back-to-back x3 <- ...; then x4 <- x3 + x3 -> second packet has rj=rk=0, qj=qk=0, tag=1.
- Same-cycle CDB tag 0 data 42 while dispatching x5 <- x3 -> vj=42, rj=1; busy[3] cleared.
- ls_in=1 with lsb_full_in=1 -> stall_out=1, no valid; release -> lsb_valid_out=1 one cycle later, tag unchanged.
- JALR dispatched as tag 2; CDB tag 2 data 0x1000 three cycles later -> rst_block_out=1 for one cycle with jalr_target_out=0x1000, FSM back to IDLE.
- flush_in during WAIT with x3 busy -> no rst_block_out pulse; next op reading x3 is ready from the regfile with tag 0.

Source files
------------

// File: rtl/op_dispatch.sv
// op_dispatch: consumer end of the fetch op-queue. Renames source operands
// against a register scoreboard (with same-cycle CDB bypass), allocates a ROB
// tag, and issues a registered dispatch packet to the RS or the LSB. Also
// tracks one outstanding JALR and pulses rst_block_out when it resolves.
//
// Handshake: the fetch side presents a bundle whenever op_in != NOP_OP; the
// bundle is consumed in any cycle where stall_out is low, rdy_in is high and
// flush_in is low. The dispatch packet is a one-cycle valid pulse
// (rs_valid_out / lsb_valid_out) with no back-pressure; downstream fullness is
// reflected through rob_full_in / rs_full_in / lsb_full_in before accept.
module op_dispatch #(
  parameter int         TAG_W   = 4,
  parameter logic [4:0] JALR_OP = 5'd19,
  parameter logic [4:0] NOP_OP  = 5'd0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [4:0]       op_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic [31:0]      imm_in,
  input  logic             branch_in,
  input  logic             ls_in,
  input  logic             use_imm_in,
  output logic             stall_out,
  output logic [4:0]       rf_rs1_addr_out,
  output logic [4:0]       rf_rs2_addr_out,
  input  logic [31:0]      rf_rs1_data_in,
  input  logic [31:0]      rf_rs2_data_in,
  input  logic             rob_full_in,
  input  logic             rs_full_in,
  input  logic             lsb_full_in,
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_data_in,
  input  logic             flush_in,
  output logic             rs_valid_out,
  output logic             lsb_valid_out,
  output logic [4:0]       d_op_out,
  output logic [4:0]       d_rd_out,
  output logic [TAG_W-1:0] d_tag_out,
  output logic [31:0]      d_vj_out,
  output logic [TAG_W-1:0] d_qj_out,
  output logic             d_rj_out,
  output logic [31:0]      d_vk_out,
  output logic [TAG_W-1:0] d_qk_out,
  output logic             d_rk_out,
  output logic [31:0]      d_imm_out,
  output logic             d_branch_out,
  output logic             rst_block_out,
  output logic [31:0]      jalr_target_out,
  output logic             jalr_state_out
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [31:0]      v;
    logic [TAG_W-1:0] q;
    logic             r;
  } opnd_t;

  // Scoreboard
  logic [31:0]      busy_q, busy_d;
  logic [TAG_W-1:0] tag_q [32];
  logic [TAG_W-1:0] tag_d [32];
  logic [TAG_W-1:0] next_tag_q, next_tag_d;

  // JALR tracker
  state_t           state_q, state_d;
  logic [TAG_W-1:0] jalr_tag_q, jalr_tag_d;
  logic             rst_block_q, rst_block_d;
  logic [31:0]      jalr_target_q, jalr_target_d;

  // Dispatch packet
  logic             rs_valid_q, rs_valid_d;
  logic             lsb_valid_q, lsb_valid_d;
  logic [4:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [TAG_W-1:0] dtag_q, dtag_d;
  logic [31:0]      vj_q, vj_d, vk_q, vk_d, imm_q, imm_d;
  logic [TAG_W-1:0] qj_q, qj_d, qk_q, qk_d;
  logic             rj_q, rj_d, rk_q, rk_d;
  logic             branch_q, branch_d;

  logic  present, target_full, accept;
  opnd_t opnd1, opnd2;

  // Ready-operands report q = 0; a busy register with a matching CDB
  // broadcast this cycle is forwarded directly.
  function automatic opnd_t resolve(input logic [4:0] rs, input logic [31:0] rf_data);
    opnd_t o;
    o.v = rf_data;
    o.q = '0;
    o.r = 1'b1;
    if (rs == 5'd0) begin
      o.v = 32'd0;
    end else if (busy_q[rs]) begin
      if (cdb_valid_in && (tag_q[rs] == cdb_tag_in)) begin
        o.v = cdb_data_in;
      end else begin
        o.v = 32'd0;
        o.q = tag_q[rs];
        o.r = 1'b0;
      end
    end
    return o;
  endfunction

  assign rf_rs1_addr_out = rs1_in;
  assign rf_rs2_addr_out = rs2_in;

  // Accept/stall decision for the bundle currently presented by fetch.
  always_comb begin
    present     = (op_in != NOP_OP);
    target_full = ls_in ? lsb_full_in : rs_full_in;
    stall_out   = !rdy_in | (present & (rob_full_in | target_full));
    accept      = present & !stall_out & !flush_in & rdy_in;
  end

  // Source renaming, using the scoreboard before this cycle's rd update.
  always_comb begin
    opnd1 = resolve(rs1_in, rf_rs1_data_in);
    opnd2 = resolve(rs2_in, rf_rs2_data_in);
    if (use_imm_in) begin
      opnd2.v = imm_in;
      opnd2.q = '0;
      opnd2.r = 1'b1;
    end
  end

  // Scoreboard next state: flush wipes, CDB clears, dispatch write wins.
  always_comb begin
    busy_d     = busy_q;
    tag_d      = tag_q;
    next_tag_d = next_tag_q;
    if (flush_in) begin
      busy_d     = '0;
      next_tag_d = '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (cdb_valid_in && busy_q[r] && (tag_q[r] == cdb_tag_in)) begin
          busy_d[r] = 1'b0;
        end
      end
      if (accept) begin
        next_tag_d = next_tag_q + TAG_W'(1);
        if (rd_in != 5'd0) begin
          busy_d[rd_in] = 1'b1;
          tag_d[rd_in]  = next_tag_q;
        end
      end
    end
  end

  // JALR tracker next state and rst_block pulse generation.
  always_comb begin
    state_d       = state_q;
    jalr_tag_d    = jalr_tag_q;
    rst_block_d   = 1'b0;
    jalr_target_d = jalr_target_q;
    if (flush_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && (op_in == JALR_OP)) begin
            state_d    = S_WAIT;
            jalr_tag_d = next_tag_q;
          end
        end
        S_WAIT: begin
          if (cdb_valid_in && (cdb_tag_in == jalr_tag_q)) begin
            rst_block_d   = 1'b1;
            jalr_target_d = cdb_data_in;
            state_d       = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Dispatch packet: valids pulse for one cycle, payload holds otherwise.
  always_comb begin
    rs_valid_d  = accept & !ls_in;
    lsb_valid_d = accept & ls_in;
    op_d        = op_q;
    rd_d        = rd_q;
    dtag_d      = dtag_q;
    vj_d        = vj_q;
    qj_d        = qj_q;
    rj_d        = rj_q;
    vk_d        = vk_q;
    qk_d        = qk_q;
    rk_d        = rk_q;
    imm_d       = imm_q;
    branch_d    = branch_q;
    if (accept) begin
      op_d     = op_in;
      rd_d     = rd_in;
      dtag_d   = next_tag_q;
      vj_d     = opnd1.v;
      qj_d     = opnd1.q;
      rj_d     = opnd1.r;
      vk_d     = opnd2.v;
      qk_d     = opnd2.q;
      rk_d     = opnd2.r;
      imm_d    = imm_in;
      branch_d = branch_in;
    end
  end

  // State registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q        <= '0;
      for (int r = 0; r < 32; r++) tag_q[r] <= '0;
      next_tag_q    <= '0;
      state_q       <= S_IDLE;
      jalr_tag_q    <= '0;
      rst_block_q   <= 1'b0;
      jalr_target_q <= '0;
      rs_valid_q    <= 1'b0;
      lsb_valid_q   <= 1'b0;
      op_q          <= '0;
      rd_q          <= '0;
      dtag_q        <= '0;
      vj_q          <= '0;
      qj_q          <= '0;
      rj_q          <= 1'b0;
      vk_q          <= '0;
      qk_q          <= '0;
      rk_q          <= 1'b0;
      imm_q         <= '0;
      branch_q      <= 1'b0;
    end else if (rdy_in) begin
      busy_q        <= busy_d;
      for (int r = 0; r < 32; r++) tag_q[r] <= tag_d[r];
      next_tag_q    <= next_tag_d;
      state_q       <= state_d;
      jalr_tag_q    <= jalr_tag_d;
      rst_block_q   <= rst_block_d;
      jalr_target_q <= jalr_target_d;
      rs_valid_q    <= rs_valid_d;
      lsb_valid_q   <= lsb_valid_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      dtag_q        <= dtag_d;
      vj_q          <= vj_d;
      qj_q          <= qj_d;
      rj_q          <= rj_d;
      vk_q          <= vk_d;
      qk_q          <= qk_d;
      rk_q          <= rk_d;
      imm_q         <= imm_d;
      branch_q      <= branch_d;
    end
  end

  assign rs_valid_out    = rs_valid_q;
  assign lsb_valid_out   = lsb_valid_q;
  assign d_op_out        = op_q;
  assign d_rd_out        = rd_q;
  assign d_tag_out       = dtag_q;
  assign d_vj_out        = vj_q;
  assign d_qj_out        = qj_q;
  assign d_rj_out        = rj_q;
  assign d_vk_out        = vk_q;
  assign d_qk_out        = qk_q;
  assign d_rk_out        = rk_q;
  assign d_imm_out       = imm_q;
  assign d_branch_out    = branch_q;
  assign rst_block_out   = rst_block_q;
  assign jalr_target_out = jalr_target_q;
  assign jalr_state_out  = state_q;

endmodule

// File: tb/tb_op_dispatch.sv
// Directed bench for op_dispatch: renaming, CDB bypass, stalls, JALR
// resolution, flush and tag wrap.
module tb_op_dispatch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [4:0]  op_in, rd_in, rs1_in, rs2_in;
  logic [31:0] imm_in;
  logic        branch_in, ls_in, use_imm_in;
  logic        stall_out;
  logic [4:0]  rf_rs1_addr_out, rf_rs2_addr_out;
  logic [31:0] rf_rs1_data_in, rf_rs2_data_in;
  logic        rob_full_in, rs_full_in, lsb_full_in;
  logic        cdb_valid_in;
  logic [3:0]  cdb_tag_in;
  logic [31:0] cdb_data_in;
  logic        flush_in;
  logic        rs_valid_out, lsb_valid_out;
  logic [4:0]  d_op_out, d_rd_out;
  logic [3:0]  d_tag_out, d_qj_out, d_qk_out;
  logic [31:0] d_vj_out, d_vk_out, d_imm_out;
  logic        d_rj_out, d_rk_out, d_branch_out;
  logic        rst_block_out;
  logic [31:0] jalr_target_out;
  logic        jalr_state_out;

  int n_checks = 0;
  int n_fail   = 0;

  op_dispatch #(.TAG_W(4), .JALR_OP(5'd19), .NOP_OP(5'd0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .op_in(op_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .imm_in(imm_in), .branch_in(branch_in), .ls_in(ls_in), .use_imm_in(use_imm_in),
    .stall_out(stall_out),
    .rf_rs1_addr_out(rf_rs1_addr_out), .rf_rs2_addr_out(rf_rs2_addr_out),
    .rf_rs1_data_in(rf_rs1_data_in), .rf_rs2_data_in(rf_rs2_data_in),
    .rob_full_in(rob_full_in), .rs_full_in(rs_full_in), .lsb_full_in(lsb_full_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .flush_in(flush_in),
    .rs_valid_out(rs_valid_out), .lsb_valid_out(lsb_valid_out),
    .d_op_out(d_op_out), .d_rd_out(d_rd_out), .d_tag_out(d_tag_out),
    .d_vj_out(d_vj_out), .d_qj_out(d_qj_out), .d_rj_out(d_rj_out),
    .d_vk_out(d_vk_out), .d_qk_out(d_qk_out), .d_rk_out(d_rk_out),
    .d_imm_out(d_imm_out), .d_branch_out(d_branch_out),
    .rst_block_out(rst_block_out), .jalr_target_out(jalr_target_out),
    .jalr_state_out(jalr_state_out)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", name, obs, exp);
      $error("check %s", name);
    end
  endtask

  // Advance one clock; outputs settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
    op_in      = op;
    rd_in      = rd;
    rs1_in     = rs1;
    rs2_in     = rs2;
    imm_in     = 32'd0;
    ls_in      = 1'b0;
    use_imm_in = 1'b0;
    branch_in  = 1'b0;
  endtask

  task automatic drive_cdb(input logic v, input logic [3:0] t, input logic [31:0] d);
    cdb_valid_in = v;
    cdb_tag_in   = t;
    cdb_data_in  = d;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    drive_op(5'd0, 5'd0, 5'd0, 5'd0);
    rf_rs1_data_in = 32'd0; rf_rs2_data_in = 32'd0;
    rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0;
    drive_cdb(1'b0, 4'd0, 32'd0);
    flush_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Reset state
    chk("rst_rs_valid", 32'(rs_valid_out), 32'd0);
    chk("rst_lsb_valid", 32'(lsb_valid_out), 32'd0);
    chk("rst_tag", 32'(d_tag_out), 32'd0);
    chk("rst_vj", d_vj_out, 32'd0);
    chk("rst_block", 32'(rst_block_out), 32'd0);
    chk("rst_target", jalr_target_out, 32'd0);
    chk("rst_state", 32'(jalr_state_out), 32'd0);
    chk("rst_stall_nop", 32'(stall_out), 32'd0);

    // ADD x3 = x1 + x2, regfile 5/7
    drive_op(5'd1, 5'd3, 5'd1, 5'd2);
    rf_rs1_data_in = 32'd5; rf_rs2_data_in = 32'd7;
    #1;
    chk("add_stall", 32'(stall_out), 32'd0);
    chk("add_rf_addr1", 32'(rf_rs1_addr_out), 32'd1);
    tick();
    chk("add_rs_valid", 32'(rs_valid_out), 32'd1);
    chk("add_lsb_valid", 32'(lsb_valid_out), 32'd0);
    chk("add_tag", 32'(d_tag_out), 32'd0);
    chk("add_vj", d_vj_out, 32'd5);
    chk("add_vk", d_vk_out, 32'd7);
    chk("add_rj", 32'(d_rj_out), 32'd1);
    chk("add_rk", 32'(d_rk_out), 32'd1);
    chk("add_rd", 32'(d_rd_out), 32'd3);
    chk("add_op", 32'(d_op_out), 32'd1);

    // x4 = x3 + x3 back to back: both operands wait on tag 0
    drive_op(5'd1, 5'd4, 5'd3, 5'd3);
    rf_rs1_data_in = 32'd99; rf_rs2_data_in = 32'd99;
    tick();
    chk("dep_tag", 32'(d_tag_out), 32'd1);
    chk("dep_rj", 32'(d_rj_out), 32'd0);
    chk("dep_qj", 32'(d_qj_out), 32'd0);
    chk("dep_rk", 32'(d_rk_out), 32'd0);
    chk("dep_qk", 32'(d_qk_out), 32'd0);

    // x5 = x3 with same-cycle CDB tag 0 = 42
    drive_op(5'd1, 5'd5, 5'd3, 5'd0);
    drive_cdb(1'b1, 4'd0, 32'd42);
    tick();
    drive_cdb(1'b0, 4'd0, 32'd0);
    chk("byp_tag", 32'(d_tag_out), 32'd2);
    chk("byp_vj", d_vj_out, 32'd42);
    chk("byp_rj", 32'(d_rj_out), 32'd1);
    chk("byp_vk_x0", d_vk_out, 32'd0);
    chk("byp_rk_x0", 32'(d_rk_out), 32'd1);

    // x6 = x3 + x4: x3 cleared by CDB, x4 still waiting on tag 1
    drive_op(5'd1, 5'd6, 5'd3, 5'd4);
    rf_rs1_data_in = 32'd11; rf_rs2_data_in = 32'd12;
    tick();
    chk("clr_tag", 32'(d_tag_out), 32'd3);
    chk("clr_vj", d_vj_out, 32'd11);
    chk("clr_rj", 32'(d_rj_out), 32'd1);
    chk("clr_rk", 32'(d_rk_out), 32'd0);
    chk("clr_qk", 32'(d_qk_out), 32'd1);

    // Bubble: no valid, payload held
    drive_op(5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("nop_rs_valid", 32'(rs_valid_out), 32'd0);
    chk("nop_tag_hold", 32'(d_tag_out), 32'd3);

    // Load/store with LSB full: stall, then release (RS full must not matter)
    drive_op(5'd2, 5'd7, 5'd0, 5'd0);
    ls_in = 1'b1; use_imm_in = 1'b1; imm_in = 32'h10;
    lsb_full_in = 1'b1;
    #1;
    chk("lsb_stall", 32'(stall_out), 32'd1);
    tick();
    chk("lsb_full_valid", 32'(lsb_valid_out), 32'd0);
    tick();
    chk("lsb_full_valid2", 32'(lsb_valid_out), 32'd0);
    lsb_full_in = 1'b0; rs_full_in = 1'b1;
    #1;
    chk("lsb_release_stall", 32'(stall_out), 32'd0);
    tick();
    rs_full_in = 1'b0;
    chk("lsb_valid", 32'(lsb_valid_out), 32'd1);
    chk("lsb_rs_valid", 32'(rs_valid_out), 32'd0);
    chk("lsb_tag", 32'(d_tag_out), 32'd4);
    chk("lsb_vk_imm", d_vk_out, 32'h10);
    chk("lsb_imm", d_imm_out, 32'h10);

    // ROB full stalls any op
    drive_op(5'd1, 5'd0, 5'd0, 5'd0);
    rob_full_in = 1'b1;
    #1;
    chk("rob_stall", 32'(stall_out), 32'd1);
    tick();
    rob_full_in = 1'b0;
    chk("rob_no_valid", 32'(rs_valid_out), 32'd0);

    // JALR x1 <- x6 (x6 waits on tag 3), allocated tag 5
    drive_op(5'd19, 5'd1, 5'd6, 5'd0);
    tick();
    drive_op(5'd0, 5'd0, 5'd0, 5'd0);
    chk("jalr_tag", 32'(d_tag_out), 32'd5);
    chk("jalr_qj", 32'(d_qj_out), 32'd3);
    chk("jalr_state_wait", 32'(jalr_state_out), 32'd1);

    // Frozen cycle with the JALR result on CDB: nothing happens
    rdy_in = 1'b0;
    drive_cdb(1'b1, 4'd5, 32'h1000);
    #1;
    chk("frz_stall", 32'(stall_out), 32'd1);
    tick();
    chk("frz_block", 32'(rst_block_out), 32'd0);
    chk("frz_state", 32'(jalr_state_out), 32'd1);
    rdy_in = 1'b1;

    // Unrelated CDB tag: no pulse
    drive_cdb(1'b1, 4'd3, 32'd1);
    tick();
    chk("jalr_other_block", 32'(rst_block_out), 32'd0);

    // Matching CDB tag 5: one-cycle pulse with target
    drive_cdb(1'b1, 4'd5, 32'h1000);
    tick();
    drive_cdb(1'b0, 4'd0, 32'd0);
    chk("jalr_block", 32'(rst_block_out), 32'd1);
    chk("jalr_target", jalr_target_out, 32'h1000);
    chk("jalr_state_idle", 32'(jalr_state_out), 32'd0);
    tick();
    chk("jalr_block_pulse", 32'(rst_block_out), 32'd0);
    chk("jalr_target_hold", jalr_target_out, 32'h1000);

    // x3 re-written (tag 6), then JALR (tag 7), then flush during WAIT
    drive_op(5'd1, 5'd3, 5'd0, 5'd0);
    tick();
    chk("pre_flush_tag", 32'(d_tag_out), 32'd6);
    drive_op(5'd19, 5'd0, 5'd0, 5'd0);
    tick();
    chk("jalr2_tag", 32'(d_tag_out), 32'd7);
    chk("jalr2_state", 32'(jalr_state_out), 32'd1);
    drive_op(5'd1, 5'd8, 5'd0, 5'd0);
    drive_cdb(1'b1, 4'd7, 32'h2000);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    drive_cdb(1'b0, 4'd0, 32'd0);
    chk("flush_rs_valid", 32'(rs_valid_out), 32'd0);
    chk("flush_block", 32'(rst_block_out), 32'd0);
    chk("flush_state", 32'(jalr_state_out), 32'd0);

    // After flush x3 comes from the regfile and tags restart at 0
    drive_op(5'd1, 5'd9, 5'd3, 5'd0);
    rf_rs1_data_in = 32'h33;
    tick();
    chk("post_flush_valid", 32'(rs_valid_out), 32'd1);
    chk("post_flush_tag", 32'(d_tag_out), 32'd0);
    chk("post_flush_vj", d_vj_out, 32'h33);
    chk("post_flush_rj", 32'(d_rj_out), 32'd1);

    // Tag wrap: 16 more accepts run tags 1..15 then 0
    drive_op(5'd1, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("wrap_tag_%0d", i), 32'(d_tag_out), 32'(i % 16));
    end
    drive_op(5'd0, 5'd0, 5'd0, 5'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
